divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 28 ++
 rtl/divider.sv | 116 +++++++++++
 2 files changed

// File: rtl/divider_pkg.sv
// Shared ALU op encodings and divider FSM encodings.
package divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Counter value on the last of the 32 restoring steps.
  localparam logic [5:0] DIV_ITER_LAST = 6'd31;

  function automatic logic op_is_signed(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input alu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per BUSY cycle on unsigned
// magnitudes, with a fast path for divide-by-zero and signed overflow.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state, w_state_nxt;
  alu_op_e         r_op;
  logic            r_neg_q, r_neg_r;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_div, r_quot, r_rem, r_res;

  alu_op_e         w_op;
  logic            w_signed, w_accept, w_b_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_fast_res;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quot_nxt, w_final_res;

  assign w_op     = alu_op_e'(i_op);
  assign w_signed = op_is_signed(w_op);
  assign w_accept = (r_state == ST_IDLE) && i_valid && !i_kill;
  assign w_b_zero = (i_b == '0);
  assign w_ovf    = w_signed && (i_a == MIN_NEG) && (i_b == '1);
  assign w_fast   = w_b_zero || w_ovf;

  assign w_abs_a = (w_signed && i_a[XLEN-1]) ? (~i_a + 1'b1) : i_a;
  assign w_abs_b = (w_signed && i_b[XLEN-1]) ? (~i_b + 1'b1) : i_b;

  always_comb begin
    w_fast_res = '0;
    if (w_b_zero) begin
      w_fast_res = op_is_rem(w_op) ? i_a : '1;
    end else if (w_ovf) begin
      w_fast_res = op_is_rem(w_op) ? '0 : MIN_NEG;
    end
  end

  // r_quot doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_ge       = !w_diff[XLEN];
  assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quot_nxt = {r_quot[XLEN-2:0], w_ge};

  always_comb begin
    w_final_res = '0;
    if (op_is_rem(r_op)) begin
      w_final_res = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    end else begin
      w_final_res = r_neg_q ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_DONE : ST_BUSY;
      ST_BUSY: if (r_cnt == DIV_ITER_LAST) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_kill) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_DIV;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= w_op;
        r_neg_q <= w_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
        r_neg_r <= w_signed && i_a[XLEN-1];
        r_cnt   <= '0;
        r_div   <= w_abs_b;
        r_quot  <= w_abs_a;
        r_rem   <= '0;
        if (w_fast) r_res <= w_fast_res;
      end else if (r_state == ST_BUSY) begin
        r_cnt  <= r_cnt + 6'd1;
        r_quot <= w_quot_nxt;
        r_rem  <= w_rem_nxt;
        if (r_cnt == DIV_ITER_LAST) r_res <= w_final_res;
      end
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_valid  = (r_state == ST_DONE);
  assign o_result = o_valid ? r_res : '0;

endmodule
